// File: rtl/barrel_arb.sv
// Round-robin arbiter/sequencer sharing one registered barrel rotator between two requesters.
// Optional BARREL_ARB_MODREDUCE_EN: reduce the amount modulo DATA_SIZE so every job is a single pass.
module barrel_arb #(
    parameter int unsigned DATA_SIZE = 8,
    parameter int unsigned AMT_W     = 6
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             req0,
    input  logic                             req1,
    input  logic [DATA_SIZE-1:0]             data0,
    input  logic [DATA_SIZE-1:0]             data1,
    input  logic [AMT_W-1:0]                 amt0,
    input  logic [AMT_W-1:0]                 amt1,
    output logic                             gnt0,
    output logic                             gnt1,
    output logic                             done0,
    output logic                             done1,
    output logic [DATA_SIZE-1:0]             result,
    output logic                             busy,
    output logic                             brl_load,
    output logic [$clog2(DATA_SIZE)-1:0]     brl_sel,
    output logic [DATA_SIZE-1:0]             brl_data_in,
    input  logic [DATA_SIZE-1:0]             brl_data_out
);

    localparam int unsigned SEL_W   = $clog2(DATA_SIZE);
    localparam int unsigned MAX_SEL = DATA_SIZE - 1;
    localparam int unsigned CMP_W   = ((AMT_W > SEL_W) ? AMT_W : SEL_W) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_ROT  = 2'd2,
        S_WAIT = 2'd3
    } state_t;

    state_t             state;
    logic [AMT_W-1:0]   rem;
    logic               owner;
    logic               rr;

    logic               elig0;
    logic               elig1;
    logic               accept;
    logic               pick;
    logic [DATA_SIZE-1:0] pick_data;
    logic [AMT_W-1:0]   pick_amt;
    logic [AMT_W-1:0]   start_rem;
    logic [AMT_W-1:0]   new_rem;

    // Largest rotate one barrel pass may apply: min(r, DATA_SIZE-1).
    function automatic logic [SEL_W-1:0] pass_sel(input logic [AMT_W-1:0] r);
        if (CMP_W'(r) >= CMP_W'(MAX_SEL)) begin
            return SEL_W'(MAX_SEL);
        end
        return SEL_W'(r);
    endfunction

    // Arbitration: a requester in its done cycle is skipped; on a tie the non-rr one wins.
    always_comb begin
        elig0     = req0 & ~done0;
        elig1     = req1 & ~done1;
        accept    = elig0 | elig1;
        pick      = 1'b0;
        if (elig0 && elig1) begin
            pick = ~rr;
        end else if (elig1) begin
            pick = 1'b1;
        end
        pick_data = pick ? data1 : data0;
        pick_amt  = pick ? amt1 : amt0;
`ifdef BARREL_ARB_MODREDUCE_EN
        start_rem = AMT_W'(32'(pick_amt) % DATA_SIZE);
`else
        start_rem = pick_amt;
`endif
        new_rem   = rem - AMT_W'(brl_sel);
    end

    // Sequencer: outputs are registered alongside the state they belong to.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            rem         <= '0;
            owner       <= 1'b0;
            rr          <= 1'b1;
            gnt0        <= 1'b0;
            gnt1        <= 1'b0;
            done0       <= 1'b0;
            done1       <= 1'b0;
            result      <= '0;
            busy        <= 1'b0;
            brl_load    <= 1'b0;
            brl_sel     <= '0;
            brl_data_in <= '0;
        end else begin
            done0 <= 1'b0;
            done1 <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        owner       <= pick;
                        gnt0        <= ~pick;
                        gnt1        <= pick;
                        rem         <= start_rem;
                        busy        <= 1'b1;
                        brl_load    <= 1'b1;
                        brl_sel     <= pass_sel(start_rem);
                        brl_data_in <= pick_data;
                        state       <= S_LOAD;
                    end
                end
                S_LOAD, S_ROT: begin
                    rem         <= new_rem;
                    brl_load    <= 1'b0;
                    brl_data_in <= '0;
                    if (new_rem == '0) begin
                        brl_sel <= '0;
                        state   <= S_WAIT;
                    end else begin
                        brl_sel <= pass_sel(new_rem);
                        state   <= S_ROT;
                    end
                end
                S_WAIT: begin
                    result <= brl_data_out;
                    done0  <= ~owner;
                    done1  <= owner;
                    gnt0   <= 1'b0;
                    gnt1   <= 1'b0;
                    rr     <= owner;
                    busy   <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_barrel_arb.sv
// Directed bench for barrel_arb with a behavioural model of the shared registered barrel rotator.
module tb_barrel_arb;

    logic       clk;
    logic       reset;
    logic       req0, req1;
    logic [7:0] data0, data1;
    logic [5:0] amt0, amt1;
    logic       gnt0, gnt1, done0, done1, busy, brl_load;
    logic [7:0] result, brl_data_in, brl_data_out;
    logic [2:0] brl_sel;

    int checks = 0;
    int errors = 0;

`ifdef BARREL_ARB_MODREDUCE_EN
    localparam int LAT20 = 3;
`else
    localparam int LAT20 = 5;
`endif

    barrel_arb #(.DATA_SIZE(8), .AMT_W(6)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1),
        .data0(data0), .data1(data1),
        .amt0(amt0), .amt1(amt1),
        .gnt0(gnt0), .gnt1(gnt1),
        .done0(done0), .done1(done1),
        .result(result), .busy(busy),
        .brl_load(brl_load), .brl_sel(brl_sel),
        .brl_data_in(brl_data_in), .brl_data_out(brl_data_out)
    );

    function automatic logic [7:0] ror8(input logic [7:0] x, input logic [2:0] s);
        logic [15:0] t;
        t = {x, x} >> s;
        return t[7:0];
    endfunction

    // Shared barrel: one-cycle latency, Load picks data_in, otherwise recirculates.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) brl_data_out <= 8'h00;
        else if (brl_load) brl_data_out <= ror8(brl_data_in, brl_sel);
        else brl_data_out <= ror8(brl_data_out, brl_sel);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected first-pass and later sel values for an amount of 20.
    function automatic logic [2:0] sel20(input int k);
`ifdef BARREL_ARB_MODREDUCE_EN
        return (k == 1) ? 3'd4 : 3'd0;
`else
        case (k)
            1: return 3'd7;
            2: return 3'd7;
            3: return 3'd6;
            default: return 3'd0;
        endcase
`endif
    endfunction

    task automatic test_reset();
        logic [23:0] got;
        reset = 1'b0;
        req0 = 1'b1; data0 = 8'hB4; amt0 = 6'd3;
        req1 = 1'b0; data1 = 8'h00; amt1 = 6'd0;
        step(); step(); step();
        got = {gnt0, gnt1, done0, done1, busy, brl_load, brl_sel, brl_data_in, result};
        checks++;
        if (got !== 24'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 000000", got);
        end
        reset = 1'b1;
        step();
        checks++;
        if ({gnt0, gnt1, brl_load, brl_sel, brl_data_in} !== {1'b1, 1'b0, 1'b1, 3'd3, 8'hB4}) begin
            errors++;
            $display("FAIL reset_first_accept: gnt0=%b gnt1=%b load=%b sel=%0d din=%h expected 1 0 1 3 b4",
                     gnt0, gnt1, brl_load, brl_sel, brl_data_in);
        end
        req0 = 1'b0;
        step(); step();
        checks++;
        if ({done0, result} !== {1'b1, 8'h96}) begin
            errors++;
            $display("FAIL reset_first_result: done0=%b result=%h expected 1 96", done0, result);
        end
        step();
    endtask

    task automatic test_single();
        req0 = 1'b1; data0 = 8'hB4; amt0 = 6'd3;
        step();
        checks++;
        if ({gnt0, gnt1, busy, brl_load, brl_sel, brl_data_in} !== {1'b1, 1'b0, 1'b1, 1'b1, 3'd3, 8'hB4}) begin
            errors++;
            $display("FAIL single_load: gnt0=%b gnt1=%b busy=%b load=%b sel=%0d din=%h expected 1 0 1 1 3 b4",
                     gnt0, gnt1, busy, brl_load, brl_sel, brl_data_in);
        end
        req0 = 1'b0; data0 = 8'hFF; amt0 = 6'd1;
        step();
        checks++;
        if ({gnt0, busy, brl_load, brl_sel, done0} !== {1'b1, 1'b1, 1'b0, 3'd0, 1'b0}) begin
            errors++;
            $display("FAIL single_wait: gnt0=%b busy=%b load=%b sel=%0d done0=%b expected 1 1 0 0 0",
                     gnt0, busy, brl_load, brl_sel, done0);
        end
        step();
        checks++;
        if ({done0, done1, gnt0, busy, result} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h96}) begin
            errors++;
            $display("FAIL single_done: done0=%b done1=%b gnt0=%b busy=%b result=%h expected 1 0 0 0 96",
                     done0, done1, gnt0, busy, result);
        end
        step();
        checks++;
        if ({done0, gnt0, result} !== {1'b0, 1'b0, 8'h96}) begin
            errors++;
            $display("FAIL single_hold: done0=%b gnt0=%b result=%h expected 0 0 96", done0, gnt0, result);
        end
    endtask

    task automatic test_zero();
        req0 = 1'b1; data0 = 8'h5A; amt0 = 6'd0;
        step();
        checks++;
        if ({gnt0, brl_load, brl_sel, brl_data_in} !== {1'b1, 1'b1, 3'd0, 8'h5A}) begin
            errors++;
            $display("FAIL zero_load: gnt0=%b load=%b sel=%0d din=%h expected 1 1 0 5a",
                     gnt0, brl_load, brl_sel, brl_data_in);
        end
        req0 = 1'b0;
        step();
        checks++;
        if ({gnt0, busy, done0} !== {1'b1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL zero_wait: gnt0=%b busy=%b done0=%b expected 1 1 0", gnt0, busy, done0);
        end
        step();
        checks++;
        if ({done0, result} !== {1'b1, 8'h5A}) begin
            errors++;
            $display("FAIL zero_done: done0=%b result=%h expected 1 5a", done0, result);
        end
        step();
    endtask

    task automatic test_multipass();
        req1 = 1'b1; data1 = 8'h01; amt1 = 6'd20;
        for (int k = 1; k < LAT20; k++) begin
            step();
            if (k == 1) req1 = 1'b0;
            checks++;
            if ({gnt0, gnt1, busy, brl_load, brl_sel, done1} !==
                {1'b0, 1'b1, 1'b1, (k == 1), sel20(k), 1'b0}) begin
                errors++;
                $display("FAIL multi_pass%0d: gnt1=%b load=%b sel=%0d done1=%b expected 1 %b %0d 0",
                         k, gnt1, brl_load, brl_sel, done1, (k == 1), sel20(k));
            end
        end
        step();
        checks++;
        if ({done1, done0, gnt1, result} !== {1'b1, 1'b0, 1'b0, 8'h10}) begin
            errors++;
            $display("FAIL multi_done: done1=%b done0=%b gnt1=%b result=%h expected 1 0 0 10",
                     done1, done0, gnt1, result);
        end
        step();
    endtask

    task automatic test_back_to_back();
        int  j;
        logic eg0, eg1, ed0, ed1;
        logic [7:0] er;
        req0 = 1'b1; data0 = 8'h02; amt0 = 6'd1;
        req1 = 1'b1; data1 = 8'h80; amt1 = 6'd1;
        for (int k = 1; k <= 12; k++) begin
            step();
            er = 8'h00;
            if (k % 3 == 0) begin
                j = k / 3 - 1;
                eg0 = 1'b0; eg1 = 1'b0;
                ed0 = (j % 2 == 0); ed1 = ~ed0;
                er = ed0 ? 8'h01 : 8'h40;
            end else begin
                j = k / 3;
                eg0 = (j % 2 == 0); eg1 = ~eg0;
                ed0 = 1'b0; ed1 = 1'b0;
            end
            checks++;
            if ({gnt0, gnt1, done0, done1} !== {eg0, eg1, ed0, ed1}) begin
                errors++;
                $display("FAIL b2b_order k=%0d: gnt=%b%b done=%b%b expected gnt=%b%b done=%b%b",
                         k, gnt0, gnt1, done0, done1, eg0, eg1, ed0, ed1);
            end
            checks++;
            if ((gnt0 & gnt1) | (done0 & done1)) begin
                errors++;
                $display("FAIL b2b_onehot k=%0d: gnt=%b%b done=%b%b expected no overlap",
                         k, gnt0, gnt1, done0, done1);
            end
            if (ed0 | ed1) begin
                checks++;
                if (result !== er) begin
                    errors++;
                    $display("FAIL b2b_result k=%0d: result=%h expected %h", k, result, er);
                end
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        step(); step();
        checks++;
        if ({busy, gnt0, gnt1} !== 3'b000) begin
            errors++;
            $display("FAIL b2b_drain: busy=%b gnt=%b%b expected 0 00", busy, gnt0, gnt1);
        end
    endtask

    task automatic test_reset_midjob();
        req0 = 1'b1; data0 = 8'h01; amt0 = 6'd20;
        step(); step();
        checks++;
        if ({gnt0, brl_load, brl_sel} !== {1'b1, 1'b0, sel20(2)}) begin
            errors++;
            $display("FAIL mid_pre: gnt0=%b load=%b sel=%0d expected 1 0 %0d", gnt0, brl_load, brl_sel, sel20(2));
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({gnt0, gnt1, busy, brl_load, brl_sel, done0, done1} !== 9'h0) begin
            errors++;
            $display("FAIL mid_abort: gnt=%b%b busy=%b load=%b sel=%0d done=%b%b expected all 0",
                     gnt0, gnt1, busy, brl_load, brl_sel, done0, done1);
        end
        step();
        reset = 1'b1;
        checks++;
        if ({gnt0, busy, done0} !== 3'b000) begin
            errors++;
            $display("FAIL mid_held: gnt0=%b busy=%b done0=%b expected 0 0 0", gnt0, busy, done0);
        end
        step();
        checks++;
        if ({gnt0, brl_load, brl_sel, brl_data_in} !== {1'b1, 1'b1, sel20(1), 8'h01}) begin
            errors++;
            $display("FAIL mid_restart: gnt0=%b load=%b sel=%0d din=%h expected 1 1 %0d 01",
                     gnt0, brl_load, brl_sel, brl_data_in, sel20(1));
        end
        req0 = 1'b0;
        for (int k = 2; k < LAT20; k++) begin
            step();
            checks++;
            if (done0 !== 1'b0) begin
                errors++;
                $display("FAIL mid_early_done k=%0d: done0=%b expected 0", k, done0);
            end
        end
        step();
        checks++;
        if ({done0, result} !== {1'b1, 8'h10}) begin
            errors++;
            $display("FAIL mid_done: done0=%b result=%h expected 1 10", done0, result);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_zero();
        test_multipass();
        test_back_to_back();
        test_reset_midjob();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
